// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_PC_STEP  = 1;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: one req/ack memory request in flight, queued results to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      DATA_W   = DEF_DATA_W,
    parameter int unsigned      ADDR_W   = DEF_ADDR_W,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       jump_en,
    input  logic [ADDR_W-1:0]          jump_pc,
    input  logic                       stall,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  fifo_count;

    // Request FSM: imem_addr is latched on issue so a redirect cannot disturb it.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (jump_en) begin
                    fetch_pc_d = jump_pc;
                end else if (fifo_count < CNT_W'(DEPTH)) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (imem_ack && jump_en) begin
                    fetch_pc_d = jump_pc;
                    state_d    = IDLE;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                    state_d    = IDLE;
                end else if (jump_en) begin
                    fetch_pc_d = jump_pc;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                if (jump_en)  fetch_pc_d = jump_pc;
                if (imem_ack) state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign pop = instr_valid && instr_ready && !stall && !jump_en;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (jump_en),
        .push_data ({addr_q, imem_data}),
        .head      (head),
        .count     (fifo_count)
    );

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = (fifo_count != '0);
    assign instr_pc    = head[ENT_W-1:DATA_W];
    assign instr       = head[DATA_W-1:0];
    assign count       = fifo_count;

endmodule
